alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational ALU. Supports ADD, SUB, CMP and SQR, and adds a full MUL.
- Operands are accepted over a valid/ready handshake.
- ADD, SUB and CMP complete in one cycle.
- SQR and MUL run on a shared iterative shift-add multiplier.
- Results are held until the consumer accepts them, so the block can sit between pipeline stages or a register file and a writeback stage.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_seq_if.sv | 39 +++
 rtl/shift_add_mult.sv | 57 +++++
 rtl/alu_seq.sv | 131 +++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encodings and helpers for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_SQR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // True for the opcodes that run on the iterative multiplier.
  function automatic logic is_mult_op(input logic [2:0] sel);
    return (sel == OP_SQR) || (sel == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of the sequential ALU.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both 1. A producer holds its payload stable while valid=1 and ready=0;
// valid never waits on ready. The input side (in_valid/in_ready) carries
// A, B, Cin, Bin, sel; the output side (out_valid/out_ready) carries Y and
// the flags, which stay stable until the result is taken.
interface alu_seq_if #(parameter int DATA_WIDTH = 8);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     A;
  logic [DATA_WIDTH-1:0]     B;
  logic                      Cin;
  logic                      Bin;
  logic [2:0]                sel;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*DATA_WIDTH-1:0]   Y;
  logic                      Cout;
  logic                      Bout;
  logic                      gr;
  logic                      le;
  logic                      eq;
  logic                      err;

  // Requester side: presents operands, consumes results.
  modport master (
    output in_valid, A, B, Cin, Bin, sel, out_ready,
    input  in_ready, out_valid, Y, Cout, Bout, gr, le, eq, err
  );

  // ALU side.
  modport slave (
    input  in_valid, A, B, Cin, Bin, sel, out_ready,
    output in_ready, out_valid, Y, Cout, Bout, gr, le, eq, err
  );

endinterface

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// DATA_WIDTH cycles per multiply. done pulses in the cycle of the final
// step, with product already showing the full 2N-bit result.
module shift_add_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int N     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   a_sh;
  logic [N-1:0]     b_sh;
  logic [2*N-1:0]   acc_nxt;

  // Next accumulator value; the last step is visible before it is stored.
  always_comb begin
    acc_nxt = acc;
    if (b_sh[0]) acc_nxt = acc + a_sh;
    done    = busy && (cnt == CNT_W'(N - 1));
    product = acc_nxt;
  end

  // Load on start, then shift a left / b right once per step; cnt never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= {{N{1'b0}}, a};
      b_sh <= b;
    end else if (busy) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshake FSM plus single-cycle ADD/SUB/CMP datapath,
// with SQR/MUL delegated to the shared shift-add multiplier. Results are
// held in registers until the consumer accepts them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output alu_state_t  state_dbg
);

  localparam int N = DATA_WIDTH;

  alu_state_t state, state_nxt;

  logic           accept;
  logic           mult_start;
  logic           mult_done;
  logic [N-1:0]   mult_b;
  logic [2*N-1:0] mult_product;

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [2*N-1:0] res_y;
  logic           res_cout, res_bout, res_gr, res_le, res_eq, res_err;

  logic [2*N-1:0] y_q;
  logic           cout_q, bout_q, gr_q, le_q, eq_q, err_q;

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.Y         = y_q;
  assign bus.Cout      = cout_q;
  assign bus.Bout      = bout_q;
  assign bus.gr        = gr_q;
  assign bus.le        = le_q;
  assign bus.eq        = eq_q;
  assign bus.err       = err_q;
  assign state_dbg     = state;

  assign accept     = bus.in_valid && bus.in_ready;
  assign mult_start = accept && is_mult_op(bus.sel);
  // SQR reuses the multiplier with both operands taken from A.
  assign mult_b     = (bus.sel == OP_SQR) ? bus.A : bus.B;

  shift_add_mult #(.DATA_WIDTH(N)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .a       (bus.A),
    .b       (mult_b),
    .done    (mult_done),
    .product (mult_product)
  );

  // Single-cycle results from the operands presented at acceptance.
  // The SUB borrow is the sign bit of the N+1-bit difference.
  always_comb begin
    sum      = {1'b0, bus.A} + {1'b0, bus.B} + (N+1)'(bus.Cin);
    diff     = {1'b0, bus.A} - {1'b0, bus.B} - (N+1)'(bus.Bin);
    res_y    = '0;
    res_cout = 1'b0;
    res_bout = 1'b0;
    res_gr   = 1'b0;
    res_le   = 1'b0;
    res_eq   = 1'b0;
    res_err  = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        res_y    = (2*N)'(sum);
        res_cout = sum[N];
      end
      OP_SUB: begin
        res_y    = (2*N)'(diff[N-1:0]);
        res_bout = diff[N];
      end
      OP_CMP: begin
        res_gr = bus.A > bus.B;
        res_le = bus.A < bus.B;
        res_eq = bus.A == bus.B;
      end
      OP_SQR, OP_MUL: ;
      default: res_err = 1'b1;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> (CALC ->) DONE -> IDLE on retirement.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mult_op(bus.sel) ? ST_CALC : ST_DONE;
      ST_CALC: if (mult_done) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers: loaded at acceptance (flags cleared for multiplies)
  // and again with the product on the final multiplier step.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      bout_q <= 1'b0;
      gr_q   <= 1'b0;
      le_q   <= 1'b0;
      eq_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      y_q    <= res_y;
      cout_q <= res_cout;
      bout_q <= res_bout;
      gr_q   <= res_gr;
      le_q   <= res_le;
      eq_q   <= res_eq;
      err_q  <= res_err;
    end else if ((state == ST_CALC) && mult_done) begin
      y_q <= mult_product;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DATA_WIDTH=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  alu_state_t state_dbg;
  int         n_checks;
  int         n_fail;

  alu_seq_if #(.DATA_WIDTH(8)) bus ();

  alu_seq #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {Cout, Bout, gr, le, eq, err}.
  function automatic logic [5:0] flags();
    return {bus.Cout, bus.Bout, bus.gr, bus.le, bus.eq, bus.err};
  endfunction

  // Present one operation, wait for acceptance, then for out_valid.
  // lat counts cycles from acceptance to out_valid (1 = next cycle).
  // busy_ok drops if in_ready is seen high before the result appears.
  task automatic do_op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic bi, output int lat, output bit busy_ok);
    int w;
    w = 0;
    bus.sel = s; bus.A = a; bus.B = b; bus.Cin = c; bus.Bin = bi;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must have no effect.
    bus.in_valid = 1'b0;
    bus.A = 8'h5A; bus.B = 8'hA5; bus.sel = OP_ADD; bus.Cin = 1'b1; bus.Bin = 1'b1;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
  endtask

  // Accept the current result with a single out_ready pulse.
  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b expected 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.Y !== 16'd0) begin n_fail++; $display("FAIL rst_y: got %0d expected 0", bus.Y); end
    n_checks++; if (flags() !== 6'b0) begin n_fail++; $display("FAIL rst_flags: got %b expected 000000", flags()); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_add();
    int lat; bit ok;
    do_op(OP_ADD, 8'd200, 8'd100, 1'b1, 1'b0, lat, ok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add1_latency: got %0d expected 1", lat); end
    n_checks++; if (bus.Y !== 16'd301) begin n_fail++; $display("FAIL add1_y: got %0d expected 301", bus.Y); end
    n_checks++; if (flags() !== 6'b100000) begin n_fail++; $display("FAIL add1_flags: got %b expected 100000", flags()); end
    retire();
    do_op(OP_ADD, 8'd10, 8'd5, 1'b0, 1'b0, lat, ok);
    n_checks++; if (bus.Y !== 16'd15) begin n_fail++; $display("FAIL add2_y: got %0d expected 15", bus.Y); end
    n_checks++; if (flags() !== 6'b000000) begin n_fail++; $display("FAIL add2_flags: got %b expected 000000", flags()); end
    retire();
  endtask

  task automatic test_sub();
    int lat; bit ok;
    do_op(OP_SUB, 8'd254, 8'd255, 1'b0, 1'b0, lat, ok);
    n_checks++; if (bus.Y !== 16'd255) begin n_fail++; $display("FAIL sub1_y: got %0d expected 255", bus.Y); end
    n_checks++; if (flags() !== 6'b010000) begin n_fail++; $display("FAIL sub1_flags: got %b expected 010000", flags()); end
    retire();
    do_op(OP_SUB, 8'd254, 8'd255, 1'b0, 1'b1, lat, ok);
    n_checks++; if (bus.Y !== 16'd254) begin n_fail++; $display("FAIL sub2_y: got %0d expected 254", bus.Y); end
    n_checks++; if (flags() !== 6'b010000) begin n_fail++; $display("FAIL sub2_flags: got %b expected 010000", flags()); end
    retire();
    do_op(OP_SUB, 8'd9, 8'd4, 1'b0, 1'b1, lat, ok);
    n_checks++; if (bus.Y !== 16'd4) begin n_fail++; $display("FAIL sub3_y: got %0d expected 4", bus.Y); end
    n_checks++; if (flags() !== 6'b000000) begin n_fail++; $display("FAIL sub3_flags: got %b expected 000000", flags()); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sub3_latency: got %0d expected 1", lat); end
    retire();
  endtask

  task automatic test_cmp();
    int lat; bit ok;
    do_op(OP_CMP, 8'd77, 8'd77, 1'b1, 1'b1, lat, ok);
    n_checks++; if (bus.Y !== 16'd0) begin n_fail++; $display("FAIL cmp_eq_y: got %0d expected 0", bus.Y); end
    n_checks++; if (flags() !== 6'b000010) begin n_fail++; $display("FAIL cmp_eq_flags: got %b expected 000010", flags()); end
    retire();
    do_op(OP_CMP, 8'd3, 8'd9, 1'b0, 1'b0, lat, ok);
    n_checks++; if (flags() !== 6'b000100) begin n_fail++; $display("FAIL cmp_le_flags: got %b expected 000100", flags()); end
    retire();
    do_op(OP_CMP, 8'd200, 8'd1, 1'b0, 1'b0, lat, ok);
    n_checks++; if (flags() !== 6'b001000) begin n_fail++; $display("FAIL cmp_gr_flags: got %b expected 001000", flags()); end
    retire();
  endtask

  task automatic test_mult();
    int lat; bit ok;
    do_op(OP_MUL, 8'd255, 8'd255, 1'b0, 1'b0, lat, ok);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL mul_latency: got %0d expected 9", lat); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_low: got %0b expected 1", ok); end
    n_checks++; if (bus.Y !== 16'd65025) begin n_fail++; $display("FAIL mul_y: got %0d expected 65025", bus.Y); end
    n_checks++; if (flags() !== 6'b000000) begin n_fail++; $display("FAIL mul_flags: got %b expected 000000", flags()); end
    retire();
    do_op(OP_MUL, 8'd13, 8'd11, 1'b0, 1'b0, lat, ok);
    n_checks++; if (bus.Y !== 16'd143) begin n_fail++; $display("FAIL mul2_y: got %0d expected 143", bus.Y); end
    retire();
    do_op(OP_SQR, 8'd16, 8'd0, 1'b0, 1'b0, lat, ok);
    n_checks++; if (bus.Y !== 16'd256) begin n_fail++; $display("FAIL sqr_y: got %0d expected 256", bus.Y); end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL sqr_latency: got %0d expected 9", lat); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat; bit ok; bit stable;
    do_op(OP_ADD, 8'd128, 8'd128, 1'b0, 1'b0, lat, ok);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.Y !== 16'd256 || flags() !== 6'b100000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0b expected 1 (Y=%0d flags=%b)", stable, bus.Y, flags()); end
    retire();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after: got %0b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_after: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int lat; bit ok; bit seen;
    bus.sel = OP_MUL; bus.A = 8'd100; bus.B = 8'd3; bus.Cin = 1'b0; bus.Bin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (state_dbg !== ST_CALC) begin n_fail++; $display("FAIL rmid_state: got %0d expected %0d", state_dbg, ST_CALC); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready_rst: got %0b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready_after: got %0b expected 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %0b expected 0", seen); end
    do_op(OP_ADD, 8'd1, 8'd1, 1'b0, 1'b0, lat, ok);
    n_checks++; if (bus.Y !== 16'd2) begin n_fail++; $display("FAIL rmid_add_y: got %0d expected 2", bus.Y); end
    retire();
  endtask

  task automatic test_illegal();
    int lat; bit ok;
    do_op(3'd5, 8'd3, 8'd4, 1'b1, 1'b1, lat, ok);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ill_latency: got %0d expected 1", lat); end
    n_checks++; if (bus.Y !== 16'd0) begin n_fail++; $display("FAIL ill_y: got %0d expected 0", bus.Y); end
    n_checks++; if (flags() !== 6'b000001) begin n_fail++; $display("FAIL ill_flags: got %b expected 000001", flags()); end
    retire();
    // A following legal op must clear err.
    do_op(OP_SUB, 8'd50, 8'd20, 1'b0, 1'b0, lat, ok);
    n_checks++; if (bus.Y !== 16'd30 || flags() !== 6'b000000) begin n_fail++; $display("FAIL ill_clear: got Y=%0d flags=%b expected Y=30 flags=000000", bus.Y, flags()); end
    retire();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Bin = 1'b0; bus.sel = OP_ADD;
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_mult();
    test_backpressure();
    test_reset_mid_op();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
